// File: rtl/x9_run_pkg.sv
// -----------------------------------------------------------------------------
// x9_run_pkg
// Shared types and default constants for the X9 host-side run controller.
//   state_e        : run controller FSM states
//   CW_DEF         : default cycle counter / report width
//   MAX_CYC_DEF    : default timeout limit in cycles (must be < 2**CW)
//   RST_CYC_DEF    : default number of cycles core_reset is held after start
//   DONE_SYNC_LAT  : latency of the optional core_done synchronizer
// -----------------------------------------------------------------------------
package x9_run_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RST  = 3'd1,
      REQ  = 3'd2,
      RUN  = 3'd3,
      FIN  = 3'd4
   } state_e;

   localparam int CW_DEF        = 32;
   localparam int MAX_CYC_DEF   = 100000;
   localparam int RST_CYC_DEF   = 4;
   localparam int DONE_SYNC_LAT = 2;

endpackage

// File: rtl/x9_sync2.sv
// -----------------------------------------------------------------------------
// x9_sync2
// Two-flop synchronizer for a single-bit level, asynchronous active-low reset
// clears both stages to 0.
// Ports:
//   clk   in  : destination clock, rising edge
//   rst_n in  : asynchronous active-low reset
//   i_d   in  : asynchronous input level
//   o_q   out : synchronized level, two clk edges behind i_d
// -----------------------------------------------------------------------------
module x9_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make both stages sample old values
         // at the same edge, which is what gives a true two-stage shift.
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/x9_run_ctrl.sv
// -----------------------------------------------------------------------------
// x9_run_ctrl
// Host-side run controller for the X9 processor top level. A single-cycle
// start holds the core in reset for RST_CYC cycles, pulses core_req for one
// cycle, then counts execution cycles until core_done or the MAX_CYC timeout.
// The result (cycle count, timeout flag) is latched and a finished pulse is
// issued. All outputs are registered.
//
// Configuration macro:
//   RUN_CTRL_DONE_SYNC_EN : when defined, core_done passes through x9_sync2
//                           and the latched count is compensated by the
//                           synchronizer latency (clamped at 0).
//
// Ports:
//   clk        in  : system clock, rising edge
//   reset      in  : asynchronous active-low reset of this block
//   start      in  : host run request, sampled only in IDLE
//   core_done  in  : done output of the processor top level
//   core_reset out : active-high reset to the processor
//   core_req   out : one-cycle request pulse to the processor
//   busy       out : high in every state except IDLE
//   finished   out : one-cycle pulse when a run ends (done or timeout)
//   timed_out  out : sticky timeout flag of the last run
//   cycles     out : cycle count of the last run, held until the next run ends
// -----------------------------------------------------------------------------
module x9_run_ctrl
   import x9_run_pkg::*;
#(
   parameter int CW      = CW_DEF,
   parameter int MAX_CYC = MAX_CYC_DEF,
   parameter int RST_CYC = RST_CYC_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          core_done,
   output logic          core_reset,
   output logic          core_req,
   output logic          busy,
   output logic          finished,
   output logic          timed_out,
   output logic [CW-1:0] cycles
);

   // Reset-hold counter only needs to reach RST_CYC-1.
   localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [RCW-1:0]  r_rst_cnt;
   logic [RCW-1:0]  w_rst_cnt_nxt;
   logic [CW-1:0]   r_run_cnt;
   logic [CW-1:0]   w_run_cnt_nxt;
   logic [CW-1:0]   r_cycles;
   logic [CW-1:0]   w_cycles_nxt;
   logic            r_timed_out;
   logic            w_timed_out_nxt;
   logic            r_core_reset;
   logic            r_core_req;
   logic            r_busy;
   logic            r_finished;
   logic            w_done;
   logic [CW-1:0]   w_done_cycles;

`ifdef RUN_CTRL_DONE_SYNC_EN
   x9_sync2 u_done_sync (
      .clk   (clk),
      .rst_n (reset),
      .i_d   (core_done),
      .o_q   (w_done)
   );

   // The FSM sees done DONE_SYNC_LAT cycles late; back the count off so the
   // report matches the count the core itself would see.
   assign w_done_cycles = (r_run_cnt > CW'(DONE_SYNC_LAT))
                        ? r_run_cnt - CW'(DONE_SYNC_LAT)
                        : '0;
`else
   assign w_done        = core_done;
   assign w_done_cycles = r_run_cnt;
`endif

   // Next-state and datapath updates.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_state_nxt     = r_state;
      w_rst_cnt_nxt   = r_rst_cnt;
      w_run_cnt_nxt   = r_run_cnt;
      w_cycles_nxt    = r_cycles;
      w_timed_out_nxt = r_timed_out;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt   = RST;
               w_rst_cnt_nxt = RCW'(RST_CYC - 1);
            end
         end
         RST: begin
            if (r_rst_cnt == '0) begin
               w_state_nxt = REQ;
            end else begin
               w_rst_cnt_nxt = r_rst_cnt - RCW'(1);
            end
         end
         REQ: begin
            w_run_cnt_nxt = CW'(1);
            w_state_nxt   = RUN;
         end
         RUN: begin
            // Done takes priority over a coincident timeout.
            if (w_done) begin
               w_cycles_nxt    = w_done_cycles;
               w_timed_out_nxt = 1'b0;
               w_state_nxt     = FIN;
            end else if (r_run_cnt == CW'(MAX_CYC)) begin
               w_cycles_nxt    = CW'(MAX_CYC);
               w_timed_out_nxt = 1'b1;
               w_state_nxt     = FIN;
            end else begin
               w_run_cnt_nxt = r_run_cnt + CW'(1);
            end
         end
         FIN: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs. Outputs are decoded from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_rst_cnt    <= '0;
         r_run_cnt    <= '0;
         r_cycles     <= '0;
         r_timed_out  <= 1'b0;
         r_core_reset <= 1'b1;
         r_core_req   <= 1'b0;
         r_busy       <= 1'b0;
         r_finished   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rst_cnt    <= w_rst_cnt_nxt;
         r_run_cnt    <= w_run_cnt_nxt;
         r_cycles     <= w_cycles_nxt;
         r_timed_out  <= w_timed_out_nxt;
         r_core_reset <= (w_state_nxt != REQ) && (w_state_nxt != RUN);
         r_core_req   <= (w_state_nxt == REQ);
         r_busy       <= (w_state_nxt != IDLE);
         r_finished   <= (w_state_nxt == FIN);
      end
   end

   assign core_reset = r_core_reset;
   assign core_req   = r_core_req;
   assign busy       = r_busy;
   assign finished   = r_finished;
   assign timed_out  = r_timed_out;
   assign cycles     = r_cycles;

endmodule

// File: tb/tb_x9_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_x9_run_ctrl
// Self-checking bench for x9_run_ctrl. A behavioural model derives, for each
// run, the RUN cycle in which done becomes visible, the expected report and
// the cycle of the finished pulse; every cycle of the run is compared.
// Honours RUN_CTRL_DONE_SYNC_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_x9_run_ctrl;

   localparam int CW      = 32;
   localparam int MAX_CYC = 20;
   localparam int RST_CYC = 4;
`ifdef RUN_CTRL_DONE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          start     = 1'b0;
   logic          core_done = 1'b0;
   logic          core_reset;
   logic          core_req;
   logic          busy;
   logic          finished;
   logic          timed_out;
   logic [CW-1:0] cycles;

   int checks = 0;
   int errors = 0;
   int prev_cyc = 0;
   bit prev_to  = 1'b0;

   always #5 clk = ~clk;

   x9_run_ctrl #(
      .CW      (CW),
      .MAX_CYC (MAX_CYC),
      .RST_CYC (RST_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .core_done  (core_done),
      .core_reset (core_reset),
      .core_req   (core_req),
      .busy       (busy),
      .finished   (finished),
      .timed_out  (timed_out),
      .cycles     (cycles)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model. k: first RUN cycle (1-based) in which core_done is
   // driven high and stays high; 0 = never. pre: done already high before
   // start. The controller reacts to done LAT cycles after it is driven.
   function automatic void model(input int k, input bit pre,
                                 output int eff, output int exp_cyc,
                                 output bit exp_to);
      bit found = 1'b0;
      eff = MAX_CYC;
      exp_cyc = MAX_CYC;
      exp_to = 1'b1;
      for (int j = 1; j <= MAX_CYC; j++) begin
         int src = j - LAT;
         bit hi = pre ? 1'b1 : (k > 0 && src >= k);
         if (hi && !found) begin
            found   = 1'b1;
            eff     = j;
            exp_cyc = (src > 0) ? src : 0;
            exp_to  = 1'b0;
         end
      end
   endfunction

   // One complete run, starting from an IDLE cycle and ending in the IDLE
   // cycle after FIN (ready for a back-to-back start).
   task automatic run_once(input int k, input bit pre, input bit spam,
                           input string tag);
      int eff, exp_cyc, fin_n, j;
      bit exp_to, e_rst, e_req, e_fin;
      model(k, pre, eff, exp_cyc, exp_to);
      fin_n = RST_CYC + eff + 1;
      core_done = pre;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n <= fin_n; n++) begin
         j = n - RST_CYC;
         if (n == fin_n) core_done = 1'b0;
         else core_done = pre ? 1'b1 : (k > 0 && j >= k);
         start = (spam && n < fin_n) ? 1'($urandom_range(0, 1)) : 1'b0;
         e_req = (n == RST_CYC);
         e_rst = !(n >= RST_CYC && n < fin_n);
         e_fin = (n == fin_n);
         checks += 4;
         if (core_reset !== e_rst) begin
            errors++;
            $display("FAIL %s core_reset n=%0d: got %b expected %b", tag, n, core_reset, e_rst);
         end
         if (core_req !== e_req) begin
            errors++;
            $display("FAIL %s core_req n=%0d: got %b expected %b", tag, n, core_req, e_req);
         end
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy n=%0d: got %b expected 1", tag, n, busy);
         end
         if (finished !== e_fin) begin
            errors++;
            $display("FAIL %s finished n=%0d: got %b expected %b", tag, n, finished, e_fin);
         end
         checks += 2;
         if (cycles !== CW'(e_fin ? exp_cyc : prev_cyc)) begin
            errors++;
            $display("FAIL %s cycles n=%0d: got %0d expected %0d", tag, n, cycles,
                     e_fin ? exp_cyc : prev_cyc);
         end
         if (timed_out !== (e_fin ? exp_to : prev_to)) begin
            errors++;
            $display("FAIL %s timed_out n=%0d: got %b expected %b", tag, n, timed_out,
                     e_fin ? exp_to : prev_to);
         end
         tick();
      end
      prev_cyc = exp_cyc;
      prev_to  = exp_to;
      checks += 4;
      if (busy !== 1'b0 || finished !== 1'b0 || core_reset !== 1'b1 || core_req !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after_fin: got busy=%b fin=%b rst=%b req=%b expected 0 0 1 0",
                  tag, busy, finished, core_reset, core_req);
      end
      if (cycles !== CW'(exp_cyc)) begin
         errors++;
         $display("FAIL %s cycles_held: got %0d expected %0d", tag, cycles, exp_cyc);
      end
      if (timed_out !== exp_to) begin
         errors++;
         $display("FAIL %s timed_out_held: got %b expected %b", tag, timed_out, exp_to);
      end
      if (finished !== 1'b0) begin
         errors++;
         $display("FAIL %s finished_single: got %b expected 0", tag, finished);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({core_reset, core_req, busy, finished, timed_out} !== 5'b10000 || cycles !== '0) begin
         errors++;
         $display("FAIL reset_values: got rst=%b req=%b busy=%b fin=%b to=%b cyc=%0d expected 1 0 0 0 0 0",
                  core_reset, core_req, busy, finished, timed_out, cycles);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) tick();
      checks++;
      if ({core_reset, core_req, busy, finished} !== 4'b1000) begin
         errors++;
         $display("FAIL idle_after_reset: got rst=%b req=%b busy=%b fin=%b expected 1 0 0 0",
                  core_reset, core_req, busy, finished);
      end
   endtask

   task automatic test_basic();
      run_once(5, 1'b0, 1'b0, "basic_done5");
   endtask

   task automatic test_timeout();
      run_once(0, 1'b0, 1'b0, "timeout");
   endtask

   task automatic test_done_pre();
      run_once(0, 1'b1, 1'b0, "done_pre");
   endtask

   task automatic test_back_to_back();
      run_once(9, 1'b0, 1'b1, "start_spam");
      run_once(2, 1'b0, 1'b0, "back_to_back");
   endtask

   task automatic test_done_at_max();
      run_once(MAX_CYC - LAT, 1'b0, 1'b0, "done_at_max");
      run_once(MAX_CYC - LAT + 1, 1'b0, 1'b0, "done_past_max");
   endtask

   task automatic test_reset_mid_run();
      core_done = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (RST_CYC + 7) tick();
      checks++;
      if (core_reset !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_run_state: got rst=%b busy=%b expected 0 1", core_reset, busy);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({core_reset, core_req, busy, finished, timed_out} !== 5'b10000 || cycles !== '0) begin
         errors++;
         $display("FAIL mid_run_reset: got rst=%b req=%b busy=%b fin=%b to=%b cyc=%0d expected 1 0 0 0 0 0",
                  core_reset, core_req, busy, finished, timed_out, cycles);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
      prev_cyc = 0;
      prev_to  = 1'b0;
      run_once(3, 1'b0, 1'b0, "after_mid_reset");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int k   = $urandom_range(0, MAX_CYC + 4);
         bit pre = ($urandom_range(0, 7) == 0);
         bit sp  = 1'($urandom_range(0, 1));
         run_once(k, pre, sp, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_done_pre();
      test_back_to_back();
      test_done_at_max();
      test_timeout();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
